axi_read_arbiter_2to1: RTL and testbench
========================================

Name: axi_read_arbiter_2to1

Overview:
- Shares one AXI4 read-only slave port (AR + R channels) between two AXI masters, m0 and m1.
- Grants whole bursts round-robin and holds the grant until the last beat completes.
- Generates rlast toward the masters from its own beat counter. The slave side carries no rlast.
- Sits between the masters and axi_slave_ram's read channels. Write channels bypass this block.

Parameters:
- ADDRESS_WIDTH, 8, width of araddr on all ports
- DATA_WIDTH, 32, width of rdata on all ports

Ports:
- aclk  input  1  clock; all state updates on the rising edge
- aresetn  input  1  asynchronous active-low reset
- m0_araddr / m1_araddr  input  ADDRESS_WIDTH  master read address
- m0_arlen / m1_arlen  input  8  burst length minus 1
- m0_arsize / m1_arsize  input  3  log2 of bytes per beat
- m0_arburst / m1_arburst  input  2  burst type
- m0_arvalid / m1_arvalid  input  1  master AR valid
- m0_arready / m1_arready  output  1  AR accepted by arbiter
- m0_rdata / m1_rdata  output  DATA_WIDTH  read data, both driven from s_rdata
- m0_rresp / m1_rresp  output  2  read response, both driven from s_rresp
- m0_rlast / m1_rlast  output  1  last beat of burst (arbiter-generated)
- m0_rvalid / m1_rvalid  output  1  read data valid
- m0_rready / m1_rready  input  1  master R ready
- s_araddr  output  ADDRESS_WIDTH  slave read address
- s_arlen  output  8  slave burst length minus 1
- s_arsize  output  3  slave beat size
- s_arburst  output  2  slave burst type
- s_arvalid  output  1  slave AR valid
- s_arready  input  1  slave AR ready
- s_rdata  input  DATA_WIDTH  slave read data
- s_rresp  input  2  slave read response
- s_rvalid  input  1  slave R valid
- s_rready  output  1  slave R ready

Behaviour:
- States:
  - IDLE (0)
  - ADDR (1)
  - DATA (2)
- Registers:
  - state
  - owner (1 bit)
  - prio (1 bit, the favoured master)
  - latched ar fields
  - beats_left (9 bit)
- Reset (aresetn low, asynchronous, any state including mid-burst):
  - state=IDLE, prio=0, owner=0, beats_left=0, latched fields=0.
  - All m*_arready, m*_rvalid, m*_rlast, s_arvalid, s_rready read 0 while reset is asserted and in the first IDLE cycle.
  - An interrupted slave burst is abandoned; the system resets the slave with the same aresetn.
- IDLE grant, combinational:
  - If only one master's arvalid is high, that master is granted.
  - If both are high, master prio is granted.
  - mN_arready = (state==IDLE) && granted==N.
  - Non-granted arready = 0.
- IDLE handshake (on mN_arvalid && mN_arready):
  - Latch araddr/arlen/arsize/arburst.
  - owner<=N, beats_left<={1'b0,arlen}+1 (range 1..256, no overflow), state<=ADDR.
- ADDR:
  - s_arvalid=1; s_ar* driven from the latched fields, stable until s_arready.
  - On s_arready: state<=DATA.
  - m*_arready=0.
- DATA:
  - m{owner}_rvalid = s_rvalid.
  - s_rready = m{owner}_rready.
  - Non-owner rvalid=0, and its rready is ignored.
  - m{owner}_rlast = s_rvalid && beats_left==1; non-owner rlast=0.
- DATA beat (each s_rvalid && s_rready): beats_left<=beats_left-1.
- DATA last beat (beat with beats_left==1):
  - state<=IDLE, prio<=~owner.
- Outside DATA: s_rready=0 and all m*_rvalid=0. Beats presented by the slave are held off, not dropped.
- Timing:
  - Min latency from m-AR handshake to s_arvalid: 1 cycle.
  - Min gap between last R beat and the next m-AR handshake: 1 cycle (IDLE).
- Simultaneous events:
  - A new arvalid during ADDR/DATA waits: arready stays 0 and the master must hold its request.
  - A master dropping arvalid in IDLE before the grant is legal; no state change.
- arburst/arsize are passed through unchecked. The arbiter never reorders beats.

Test Plan:
- m0 AR addr=0x10 len=3 alone, slave arready=1, rvalid=1, m0_rready=1:
  - Expect m0_arready pulse at cycle 0, s_arvalid at cycle 1.
  - Expect 4 m0 beats with rlast only on the 4th, m1_rvalid=0 throughout, state back to IDLE.
- m0 and m1 both assert arvalid continuously, each with len=1:
  - Expect grants in the order m0, m1, m0, m1.
  - Expect exactly 2 beats per grant, with rlast on the 2nd.
- m1 asserts arvalid while m0 is in DATA with len=7:
  - Expect m1_arready=0 until m0's 8th beat completes, then m1 granted next IDLE.
- m0_rready toggling 1,0,0,1 during len=3 with s_rvalid=1:
  - Expect s_rready to mirror m0_rready and beats_left to decrement only on handshake cycles.
  - Expect 4 beats total.
- m0 AR with len=255:
  - Expect 256 beats, rlast only on beat 256, no counter wrap.
- aresetn low for 1 cycle at beat 2 of a len=5 burst:
  - Expect all valids/readies 0 immediately, state=IDLE.
  - After release, expect prio=0, so m0 wins a tie.

Source files
------------

// File: rtl/axi_read_arbiter_2to1_if.sv
// AXI4 read-only channel bundle (AR + R) used on every side of
// axi_read_arbiter_2to1.
//   master modport : drives AR fields/arvalid and rready, sees arready, rdata,
//                    rresp, rvalid. The downstream slave carries no rlast, so
//                    rlast is absent from this view.
//   slave modport  : the mirror image, and also drives rlast toward the master.
interface axi_read_arbiter_2to1_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter_2to1.sv
// 2:1 AXI4 read arbiter. Two masters (m0, m1) share one read-only slave port (s).
// Whole bursts are granted round-robin and the grant is held until the last
// beat. rlast toward the masters comes from an internal beat counter.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   m0, m1        : master-facing AR/R channels (slave modport)
//   s             : slave-facing AR/R channels (master modport, no rlast)
module axi_read_arbiter_2to1 #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi_read_arbiter_2to1_if.slave  m0,
  axi_read_arbiter_2to1_if.slave  m1,
  axi_read_arbiter_2to1_if.master s
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]               state;
  logic                     owner;
  logic                     prio;
  // Low during reset and the first cycle after release, so no AR is taken
  // until the block has seen one clean clock.
  logic                     live;
  logic [ADDRESS_WIDTH-1:0] araddr_q;
  logic [7:0]               arlen_q;
  logic [2:0]               arsize_q;
  logic [1:0]               arburst_q;
  logic [8:0]               beats_left;

  logic                  gnt;
  logic                  ar_hs;
  logic                  in_data;
  logic                  last;
  logic                  beat;
  logic [DATA_WIDTH-1:0] rdata_bc;

  // Grant: a lone requester wins; on a tie the favoured master wins.
  assign gnt   = (m0.arvalid && m1.arvalid) ? prio : m1.arvalid;
  assign m0.arready = live && (state == IDLE) && m0.arvalid && !gnt;
  assign m1.arready = live && (state == IDLE) && m1.arvalid &&  gnt;
  assign ar_hs = m0.arready || m1.arready;

  assign s.arvalid = (state == ADDR);
  assign s.araddr  = araddr_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;

  assign in_data   = (state == DATA);
  assign last      = (beats_left == 9'd1);
  // Outside DATA rready stays low so slave beats are held off, never dropped.
  assign s.rready  = in_data && (owner ? m1.rready : m0.rready);
  assign beat      = in_data && s.rvalid && s.rready;

  assign m0.rvalid = in_data && !owner && s.rvalid;
  assign m1.rvalid = in_data &&  owner && s.rvalid;
  assign m0.rlast  = m0.rvalid && last;
  assign m1.rlast  = m1.rvalid && last;

  assign rdata_bc  = s.rdata;
  assign m0.rdata  = rdata_bc;
  assign m1.rdata  = rdata_bc;
  assign m0.rresp  = s.rresp;
  assign m1.rresp  = s.rresp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      live       <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      beats_left <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: if (ar_hs) begin
          owner      <= gnt;
          araddr_q   <= gnt ? m1.araddr  : m0.araddr;
          arlen_q    <= gnt ? m1.arlen   : m0.arlen;
          arsize_q   <= gnt ? m1.arsize  : m0.arsize;
          arburst_q  <= gnt ? m1.arburst : m0.arburst;
          // 9 bits so arlen=255 gives 256 without wrapping.
          beats_left <= {1'b0, gnt ? m1.arlen : m0.arlen} + 9'd1;
          state      <= ADDR;
        end
        ADDR: if (s.arready) state <= DATA;
        DATA: if (beat) begin
          beats_left <= beats_left - 9'd1;
          if (last) begin
            state <= IDLE;
            prio  <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter_2to1.sv
module tb_axi_read_arbiter_2to1;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } req_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_read_arbiter_2to1_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  axi_read_arbiter_2to1_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  axi_read_arbiter_2to1_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

  assign s_if.rlast = 1'b0;

  axi_read_arbiter_2to1 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  int unsigned total = 0, passed = 0, fails = 0;

  // Transaction-level reference: pending requests per master, the burst in
  // flight, and which master is favoured next.
  req_t q0[$], q1[$];
  bit   busy, ar_phase, fresh, own, mprio;
  req_t cur;
  int   beats_done;
  bit   rpat[$];
  int   ar_pct = 100, rv_pct = 100, rr_pct = 100;

  // Slave stimulus state.
  bit         sl_active;
  logic [7:0] sl_addr, sl_len;
  int         sl_idx;

  // Observations of the DUT's own handshakes.
  int glog[$];
  int beat_cnt0, beat_cnt1, rl_cnt0, rl_cnt1;

  function automatic logic [31:0] sdat(input logic [7:0] a, input int b);
    logic [7:0] bb;
    bb = b[7:0];
    return {a, bb, ~a, bb ^ 8'h5a};
  endfunction

  function automatic req_t mk(input logic [7:0] a, input logic [7:0] l);
    req_t r;
    r.addr = a; r.len = l; r.size = 3'd2; r.burst = 2'd1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_m0_arready"}, m0_if.arready, 0);
    chk({tag, "_m1_arready"}, m1_if.arready, 0);
    chk({tag, "_m0_rvalid"},  m0_if.rvalid,  0);
    chk({tag, "_m1_rvalid"},  m1_if.rvalid,  0);
    chk({tag, "_m0_rlast"},   m0_if.rlast,   0);
    chk({tag, "_m1_rlast"},   m1_if.rlast,   0);
    chk({tag, "_s_arvalid"},  s_if.arvalid,  0);
    chk({tag, "_s_rready"},   s_if.rready,   0);
  endtask

  task automatic drive();
    m0_if.arvalid = (q0.size() > 0);
    m0_if.araddr  = q0.size() > 0 ? q0[0].addr  : 8'h0;
    m0_if.arlen   = q0.size() > 0 ? q0[0].len   : 8'h0;
    m0_if.arsize  = q0.size() > 0 ? q0[0].size  : 3'h0;
    m0_if.arburst = q0.size() > 0 ? q0[0].burst : 2'h0;
    m1_if.arvalid = (q1.size() > 0);
    m1_if.araddr  = q1.size() > 0 ? q1[0].addr  : 8'h0;
    m1_if.arlen   = q1.size() > 0 ? q1[0].len   : 8'h0;
    m1_if.arsize  = q1.size() > 0 ? q1[0].size  : 3'h0;
    m1_if.arburst = q1.size() > 0 ? q1[0].burst : 2'h0;
    if (rpat.size() > 0) m0_if.rready = rpat.pop_front();
    else                 m0_if.rready = ($urandom_range(99) < rr_pct);
    m1_if.rready  = ($urandom_range(99) < rr_pct);
    s_if.arready  = ($urandom_range(99) < ar_pct);
    s_if.rvalid   = sl_active && ($urandom_range(99) < rv_pct);
    s_if.rdata    = sl_active ? sdat(sl_addr, sl_idx) : $urandom;
    s_if.rresp    = 2'($urandom_range(3));
  endtask

  // One clock: check outputs at the falling edge against the reference,
  // advance the reference across the rising edge, then drive new inputs.
  task automatic tick();
    bit p0, p1, can, g, dp, rdy_own, gr, arh, bt;
    @(negedge aclk);
    p0  = q0.size() > 0;
    p1  = q1.size() > 0;
    can = !busy && !fresh;
    g   = (p0 && p1) ? mprio : p1;
    dp  = busy && !ar_phase;
    rdy_own = own ? m1_if.rready : m0_if.rready;
    chk("m0_arready", m0_if.arready, can && p0 && !g);
    chk("m1_arready", m1_if.arready, can && p1 && g);
    chk("s_arvalid",  s_if.arvalid,  busy && ar_phase);
    if (busy && ar_phase) begin
      chk("s_araddr",  s_if.araddr,  cur.addr);
      chk("s_arlen",   s_if.arlen,   cur.len);
      chk("s_arsize",  s_if.arsize,  cur.size);
      chk("s_arburst", s_if.arburst, cur.burst);
    end
    chk("m0_rvalid", m0_if.rvalid, dp && !own && s_if.rvalid);
    chk("m1_rvalid", m1_if.rvalid, dp &&  own && s_if.rvalid);
    chk("s_rready",  s_if.rready,  dp && rdy_own);
    chk("m0_rlast",  m0_if.rlast,  dp && !own && s_if.rvalid && beats_done == int'(cur.len));
    chk("m1_rlast",  m1_if.rlast,  dp &&  own && s_if.rvalid && beats_done == int'(cur.len));
    chk("m0_rdata",  m0_if.rdata,  s_if.rdata);
    chk("m1_rdata",  m1_if.rdata,  s_if.rdata);
    chk("m0_rresp",  m0_if.rresp,  s_if.rresp);
    chk("m1_rresp",  m1_if.rresp,  s_if.rresp);

    if (m0_if.arvalid && m0_if.arready) glog.push_back(0);
    if (m1_if.arvalid && m1_if.arready) glog.push_back(1);
    if (m0_if.rvalid && m0_if.rready) begin beat_cnt0++; if (m0_if.rlast) rl_cnt0++; end
    if (m1_if.rvalid && m1_if.rready) begin beat_cnt1++; if (m1_if.rlast) rl_cnt1++; end

    gr  = can && (p0 || p1);
    arh = busy && ar_phase && s_if.arready;
    bt  = dp && s_if.rvalid && rdy_own;
    if (bt) begin
      beats_done++;
      if (beats_done == int'(cur.len) + 1) begin busy = 0; mprio = ~own; end
    end
    if (arh) ar_phase = 0;
    if (gr) begin
      own = g;
      cur = g ? q1.pop_front() : q0.pop_front();
      busy = 1; ar_phase = 1; beats_done = 0;
    end
    fresh = 0;

    if (s_if.rvalid && s_if.rready) begin
      sl_idx++;
      if (sl_idx > int'(sl_len)) sl_active = 0;
    end
    if (s_if.arvalid && s_if.arready) begin
      sl_active = 1; sl_addr = s_if.araddr; sl_len = s_if.arlen; sl_idx = 0;
    end

    @(posedge aclk); #1;
    drive();
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      tick(); n++;
    end
    chk({tag, "_timeout"}, (busy || q0.size() != 0 || q1.size() != 0), 0);
  endtask

  task automatic wait_data(input int budget, input int beats, input string tag);
    int n;
    n = 0;
    while (!(busy && !ar_phase && beats_done >= beats) && n < budget) begin
      tick(); n++;
    end
    chk({tag, "_timeout"}, (busy && !ar_phase && beats_done >= beats), 1);
  endtask

  task automatic clear_obs();
    glog.delete();
    beat_cnt0 = 0; beat_cnt1 = 0; rl_cnt0 = 0; rl_cnt1 = 0;
  endtask

  // Holds reset with every input that could provoke an output asserted.
  task automatic do_reset(input string tag);
    aresetn = 1'b0;
    q0.delete(); q1.delete(); rpat.delete();
    busy = 0; ar_phase = 0; mprio = 0; own = 0; beats_done = 0; sl_active = 0;
    m0_if.arvalid = 1; m1_if.arvalid = 1; m0_if.rready = 1; m1_if.rready = 1;
    s_if.arready = 1; s_if.rvalid = 1;
    #1;
    chk_quiet({tag, "_async"});
    @(negedge aclk);
    chk_quiet({tag, "_hold"});
    @(posedge aclk); #1;
  endtask

  task automatic release_rst();
    aresetn = 1'b1;
    fresh = 1;
    clear_obs();
    drive();
  endtask

  initial begin
    logic [3:0] ord;
    busy = 0; ar_phase = 0; fresh = 0; own = 0; mprio = 0; beats_done = 0;
    sl_active = 0; sl_idx = 0; sl_addr = 0; sl_len = 0;
    cur = mk(8'h0, 8'h0);
    m0_if.araddr = 0; m0_if.arlen = 0; m0_if.arsize = 0; m0_if.arburst = 0;
    m1_if.araddr = 0; m1_if.arlen = 0; m1_if.arsize = 0; m1_if.arburst = 0;
    s_if.rdata = 0; s_if.rresp = 0;

    // Reset state
    do_reset("rst0");
    release_rst();
    tick(); tick();

    // Single m0 burst, len=3
    clear_obs();
    q0.push_back(mk(8'h10, 8'd3));
    drive();
    run_idle(50, "t1");
    chk("t1_m0_beats", beat_cnt0, 4);
    chk("t1_m0_rlast", rl_cnt0, 1);
    chk("t1_m1_beats", beat_cnt1, 0);
    chk("t1_grants",   glog.size(), 1);
    tick();

    // Both masters saturating with len=1, from a fresh reset
    do_reset("rst1");
    release_rst();
    q0.push_back(mk(8'h20, 8'd1)); q0.push_back(mk(8'h24, 8'd1));
    q1.push_back(mk(8'h40, 8'd1)); q1.push_back(mk(8'h44, 8'd1));
    drive();
    run_idle(80, "t2");
    ord = 4'hf;
    for (int i = 0; i < 4 && i < glog.size(); i++) ord[3-i] = glog[i][0];
    chk("t2_ngrants", glog.size(), 4);
    chk("t2_order",   ord, 4'b0101);
    chk("t2_beats",   beat_cnt0 + beat_cnt1, 8);
    chk("t2_rlasts",  rl_cnt0 + rl_cnt1, 4);

    // m1 arrives while m0 streams a len=7 burst
    clear_obs();
    q0.push_back(mk(8'h30, 8'd7));
    drive();
    wait_data(20, 1, "t3_wait");
    q1.push_back(mk(8'h50, 8'd0));
    drive();
    run_idle(80, "t3");
    chk("t3_ngrants", glog.size(), 2);
    chk("t3_order",   {glog.size() > 1 ? glog[0][0] : 1'bx, glog.size() > 1 ? glog[1][0] : 1'bx}, 2'b01);
    chk("t3_m0_beats", beat_cnt0, 8);

    // m0 rready pattern 1,0,0,1 during a len=3 burst
    clear_obs();
    q0.push_back(mk(8'h60, 8'd3));
    drive();
    wait_data(20, 0, "t4_wait");
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_idle(50, "t4");
    chk("t4_m0_beats", beat_cnt0, 4);
    chk("t4_m0_rlast", rl_cnt0, 1);

    // Maximum burst, len=255
    clear_obs();
    q0.push_back(mk(8'h80, 8'd255));
    drive();
    run_idle(400, "t5");
    chk("t5_m0_beats", beat_cnt0, 256);
    chk("t5_m0_rlast", rl_cnt0, 1);

    // Randomized traffic with random backpressure on every channel
    clear_obs();
    ar_pct = 60; rv_pct = 65; rr_pct = 70;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) begin
        req_t r;
        r.addr = 8'($urandom); r.len = 8'($urandom_range(12));
        r.size = 3'($urandom_range(7)); r.burst = 2'($urandom_range(3));
        if ($urandom_range(1) == 0) begin if (q0.size() < 3) q0.push_back(r); end
        else                        begin if (q1.size() < 3) q1.push_back(r); end
        drive();
      end
      tick();
    end
    run_idle(3000, "rnd");
    chk("rnd_rlast_per_grant", rl_cnt0 + rl_cnt1, glog.size());
    ar_pct = 100; rv_pct = 100; rr_pct = 100;

    // Reset at beat 2 of a len=5 burst, then a tie must go to m0
    clear_obs();
    q0.push_back(mk(8'h90, 8'd5));
    drive();
    wait_data(20, 2, "t6_wait");
    do_reset("rst2");
    q0.push_back(mk(8'ha0, 8'd0));
    q1.push_back(mk(8'hb0, 8'd0));
    release_rst();
    run_idle(40, "t6");
    chk("t6_first_grant", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t6_ngrants", glog.size(), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
